// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset controller.
// MC_ADDI_EN adds the ADDIEXEC/ADDIWB states to the state enum.
package mc_pkg;

    localparam int unsigned MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9
`ifdef MC_ADDI_EN
        ,
        ADDIEXEC = 4'd10,
        ADDIWB   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Per-state control word before reset gating and the branch/funct qualifiers.
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] pcsrc;
        aluop_t     aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero in, control word out.
interface multicycle_controller_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
               iord, memtoreg, regdst, pcsrc, alucontrol
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
               iord, memtoreg, regdst, pcsrc, alucontrol
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode from aluop and funct; funct_ok flags a supported R-type funct.
module alu_decoder
    import mc_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_ok
);

    logic [2:0] funct_code;

    // funct_ok is independent of aluop so ALUWB can qualify its write with it.
    always_comb begin
        funct_ok   = 1'b1;
        funct_code = ALU_ADD;
        case (funct)
            F_ADD:   funct_code = ALU_ADD;
            F_SUB:   funct_code = ALU_SUB;
            F_AND:   funct_code = ALU_AND;
            F_OR:    funct_code = ALU_OR;
            F_SLT:   funct_code = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: alucontrol = funct_code;
            default:     alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS-subset datapath (Moore, one state per clock).
// Define MC_ADDI_EN to include the addi states; otherwise addi is an illegal opcode.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned STATE_W = MC_STATE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    logic [STATE_W-1:0] state_q;
    state_t             state;
    state_t             state_next;
    state_t             state_eff;
    ctrl_t              ctrl;
    logic               aluwb;
    logic [2:0]         alucontrol;
    logic               funct_ok;

    assign state = state_t'(state_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STATE_W'(FETCH);
        end else begin
            state_q <= STATE_W'(state_next);
        end
    end

    // During reset the control word shows FETCH values; enables are gated below.
    always_comb begin
        state_next = FETCH;
        state_eff  = rst_n ? state : FETCH;
        ctrl       = '0;
        aluwb      = 1'b0;

        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_next = ADDIEXEC;
`endif
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTE:  state_next = ALUWB;
`ifdef MC_ADDI_EN
            ADDIEXEC: state_next = ADDIWB;
`endif
            default:  state_next = FETCH;
        endcase

        case (state_eff)
            FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            DECODE: ctrl.alusrcb = SRCB_IMMSH;
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: ctrl.iord = 1'b1;
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.regdst = 1'b1;
                aluwb       = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
`ifdef MC_ADDI_EN
            ADDIEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            ADDIWB: ctrl.regwrite = 1'b1;
`endif
            JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol),
        .funct_ok   (funct_ok)
    );

    assign bus.pcen       = rst_n & (ctrl.pcwrite | (ctrl.branch & bus.zero));
    assign bus.memwrite   = rst_n & ctrl.memwrite;
    assign bus.irwrite    = rst_n & ctrl.irwrite;
    assign bus.regwrite   = rst_n & (ctrl.regwrite | (aluwb & funct_ok));
    assign bus.alusrca    = ctrl.alusrca;
    assign bus.alusrcb    = ctrl.alusrcb;
    assign bus.iord       = ctrl.iord;
    assign bus.memtoreg   = ctrl.memtoreg;
    assign bus.regdst     = ctrl.regdst;
    assign bus.pcsrc      = ctrl.pcsrc;
    assign bus.alucontrol = alucontrol;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words from an
// instruction-level model, checked by an independent monitor on the falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
    } obs_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;

    // Instruction latency in cycles from entering FETCH to re-entering FETCH.
    function automatic int n_cycles(input logic [5:0] op);
        case (op)
            LW:   return 5;
            SW:   return 4;
            RT:   return 4;
            BEQ:  return 3;
            JMP:  return 3;
`ifdef MC_ADDI_EN
            ADDI: return 4;
`endif
            default: return 2;
        endcase
    endfunction

    // {ok, alu code} for an R-type funct.
    function automatic logic [3:0] funct_model(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_010;
        endcase
    endfunction

    function automatic obs_t reset_obs();
        obs_t e;
        e            = '0;
        e.alusrcb    = 2'b01;
        e.alucontrol = 3'b010;
        return e;
    endfunction

    function automatic obs_t expect_cycle(input logic [5:0] op, input logic [5:0] f,
                                          input int step, input logic z);
        obs_t       e;
        logic [3:0] fd;
        e            = '0;
        fd           = funct_model(f);
        e.alucontrol = 3'b010;
        if (step == 0) begin
            e.alusrcb = 2'b01;
            e.irwrite = 1'b1;
            e.pcen    = 1'b1;
        end else if (step == 1) begin
            e.alusrcb = 2'b11;
        end else begin
            case (op)
                LW, SW: begin
                    if (step == 2) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else if (step == 3) begin
                        e.iord     = 1'b1;
                        e.memwrite = (op == SW);
                    end else begin
                        e.memtoreg = 1'b1;
                        e.regwrite = 1'b1;
                    end
                end
                RT: begin
                    if (step == 2) begin
                        e.alusrca    = 1'b1;
                        e.alucontrol = fd[2:0];
                    end else begin
                        e.regdst   = 1'b1;
                        e.regwrite = fd[3];
                    end
                end
                BEQ: begin
                    e.alusrca    = 1'b1;
                    e.alucontrol = 3'b110;
                    e.pcsrc      = 2'b01;
                    e.pcen       = z;
                end
`ifdef MC_ADDI_EN
                ADDI: begin
                    if (step == 2) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else begin
                        e.regwrite = 1'b1;
                    end
                end
`endif
                JMP: begin
                    e.pcsrc = 2'b10;
                    e.pcen  = 1'b1;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    // One instruction; zsel<0 randomises zero per cycle, abort_at>=0 pulses reset at that step.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input int zsel, input int abort_at);
        int   n;
        logic z;
        n = n_cycles(op);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            if (s == 0) begin
                bus.op    = op;
                bus.funct = f;
            end
            z        = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            bus.zero = z;
            if (s == abort_at) begin
                rst_n = 1'b0;
                exp_q.push_back(reset_obs());
                tag_q.push_back($sformatf("abort op=%b step=%0d", op, s));
                break;
            end
            rst_n = 1'b1;
            exp_q.push_back(expect_cycle(op, f, s, z));
            tag_q.push_back($sformatf("op=%b funct=%b step=%0d zero=%b", op, f, s, z));
        end
    endtask

    // Monitor: compare the live control word against the oldest pending expectation.
    initial begin
        obs_t  a;
        obs_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca,
                     bus.alusrcb, bus.iord, bus.memtoreg, bus.regdst, bus.pcsrc,
                     bus.alucontrol};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", t, a, e);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] functs[5];
        logic [5:0] op;
        logic [5:0] f;
        int         ab;
        ops    = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b000000};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            exp_q.push_back(reset_obs());
            tag_q.push_back($sformatf("reset cycle %0d", i));
        end

        run_instr(LW,   6'b000000, -1, -1);
        run_instr(RT,   6'b101010, -1, -1);
        run_instr(RT,   6'b111111, -1, -1);
        run_instr(BEQ,  6'b000000,  1, -1);
        run_instr(BEQ,  6'b000000,  0, -1);
        run_instr(JMP,  6'b000000, -1, -1);
        run_instr(6'b111111, 6'b000000, -1, -1);
        run_instr(SW,   6'b000000, -1,  3);
        run_instr(ADDI, 6'b000000, -1, -1);
        run_instr(LW,   6'b000000, -1,  4);

        for (int i = 0; i < 400; i++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 6) == 0) op = 6'($urandom);
            f  = ($urandom_range(0, 1) == 1) ? functs[$urandom_range(0, 4)] : 6'($urandom);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n_cycles(op) - 1) : -1;
            run_instr(op, f, -1, ab);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle MIPS-subset datapath. It is the initiator side of the ALU control interface: it decodes `op`/`funct` from the instruction register and sequences the datapath one state per clock. Per state it drives the 3-bit ALU control code and all mux selects and write enables. It consumes the ALU `zero` flag to resolve branches.

## Interface
- `STATE_W`, default 4, width of the state register; must hold all state encodings.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous active-low reset.
- `op` input 6: instruction opcode, bits [31:26], stable from DECODE onward.
- `funct` input 6: R-type function field, bits [5:0].
- `zero` input 1: ALU zero flag, same-cycle combinational from the ALU.
- `pcen` output 1: PC write enable, `pcwrite | (branch & zero)`.
- `memwrite` output 1: memory write enable.
- `irwrite` output 1: instruction register write enable.
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: ALU A select; 0 = PC, 1 = register A.
- `alusrcb` output 2: ALU B select; 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `memtoreg` output 1: writeback select; 0 = ALUOut, 1 = data register.
- `regdst` output 1: destination register select; 0 = rt, 1 = rd.
- `pcsrc` output 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` output 3: ALU control code; 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT.

## Operation
- Moore FSM. All outputs are decoded from the current state only, except `pcen`, which also uses `zero`. Any output not listed for a state is 0.
- `aluop` is internal, 2 bits:
  - 00 gives ADD.
  - 01 gives SUB.
  - 10 gives the funct-decoded code.
- Funct decode:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - Any other funct → 010, with `funct_ok` = 0.
- States, their outputs, and next states:
  - FETCH: alusrcb=01, irwrite, pcwrite. Next: DECODE.
  - DECODE: alusrcb=11. Next by opcode:
    - lw (100011) or sw (101011) → MEMADR
    - R-type (000000) → EXECUTE
    - beq (000100) → BRANCH
    - addi (001000) → ADDIEXEC
    - j (000010) → JUMP
    - any other opcode → FETCH, with no write enable asserted.
  - MEMADR: alusrca=1, alusrcb=10. Next: lw → MEMRD, sw → MEMWR.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: memtoreg=1, regwrite. Next: FETCH.
  - MEMWR: iord=1, memwrite. Next: FETCH.
  - EXECUTE: alusrca=1, aluop=10. Next: ALUWB.
  - ALUWB: regdst=1, regwrite = `funct_ok`. Next: FETCH. An unsupported funct never writes the register file.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch. Next: FETCH.
  - ADDIEXEC: alusrca=1, alusrcb=10. Next: ADDIWB.
  - ADDIWB: regwrite. Next: FETCH.
  - JUMP: pcsrc=10, pcwrite. Next: FETCH.
- `op` is sampled in DECODE and again in MEMADR. The datapath holds the IR constant between FETCH writes.

## Timing
- Reset: while `rst_n`=0 at a rising edge, the state becomes FETCH.
  - While `rst_n`=0, `pcen`, `memwrite`, `irwrite` and `regwrite` are forced to 0 combinationally.
  - All other outputs take their FETCH values.
- Reset asserted in any state aborts the instruction; the next cycle with `rst_n` high begins a fresh FETCH.
- Cycles per instruction, counted from entering FETCH to re-entering FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Branch: `pcen` goes high in BRANCH only when `zero`=1 in that same cycle.

## Configuration
- `MC_ADDI_EN` defined: ADDIEXEC and ADDIWB are compiled in, and addi executes as described above.
- `MC_ADDI_EN` undefined: both states are removed, and op 001000 takes the illegal-opcode path (DECODE → FETCH, no write).

## Structure
- Package `mc_pkg` holds:
  - state enum localparams
  - opcode constants
  - funct constants
  - ALU control codes (000/001/010/110/111)
  - aluop encodings
- Sub-module `alu_decoder`: combinational; inputs `aluop` and `funct`; outputs `alucontrol` and `funct_ok`. It is instantiated once.

## Test plan
- Reset held 3 cycles, then op=100011 (lw) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - irwrite=pcen=1 only in FETCH; iord=1 in MEMRD; memtoreg=regwrite=1 in MEMWB.
  - No write enables during reset.
- op=000000, funct=101010 → alucontrol=111 in EXECUTE; regdst=regwrite=1 in ALUWB.
- op=000000, funct=111111 → alucontrol=010 in EXECUTE; regwrite=0 in ALUWB.
- op=000100 with zero=1 → pcen=1, pcsrc=01, alucontrol=110 in BRANCH. Repeat with zero=0 → pcen=0.
- op=000010 → JUMP with pcsrc=10, pcen=1, then FETCH. op=111111 → DECODE → FETCH with no writes.
- rst_n dropped for 1 cycle during MEMWR → memwrite=0 in that cycle; FETCH follows.
- Without `MC_ADDI_EN`: op=001000 → DECODE → FETCH with regwrite=0. With it: ADDIWB asserts regwrite=1, regdst=0.
